// File: rtl/hub75_gamma_seq_if.sv
// Bus bundle for hub75_gamma_seq: pixel in/out streams, host LUT write port and LUT access port.
// Optional bypass line is present only when HUB75_GAMMA_SEQ_BYPASS_EN is defined.
interface hub75_gamma_seq_if #(
  parameter int IW = 8,
  parameter int OW = 10
);
  // valid/ready: a transfer happens on a rising clk edge where both are high;
  // the source holds data stable while valid is high and ready is low.
  logic [3*IW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [3*OW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   wr_addr;
  logic [OW-1:0]   wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [IW-1:0]   lut_addr;
  logic            lut_rden;
  logic            lut_wren;
  logic [OW-1:0]   lut_wdata;
  logic [OW-1:0]   lut_rdata;
`ifdef HUB75_GAMMA_SEQ_BYPASS_EN
  logic            bypass;
`endif

  modport master (
`ifdef HUB75_GAMMA_SEQ_BYPASS_EN
    input  bypass,
`endif
    input  in_data, in_valid, output in_ready,
    output out_data, out_valid, input out_ready,
    input  wr_addr, wr_data, wr_valid, output wr_ready,
    output lut_addr, lut_rden, lut_wren, lut_wdata, input lut_rdata
  );

  modport slave (
`ifdef HUB75_GAMMA_SEQ_BYPASS_EN
    output bypass,
`endif
    output in_data, in_valid, input in_ready,
    input  out_data, out_valid, output out_ready,
    output wr_addr, wr_data, wr_valid, input wr_ready,
    input  lut_addr, lut_rden, lut_wren, lut_wdata, output lut_rdata
  );
endinterface

// File: rtl/hub75_gamma_seq.sv
// Shared gamma-LUT sequencer: three serial R/G/B lookups per pixel, round-robin with host writes.
// Optional feature macro: HUB75_GAMMA_SEQ_BYPASS_EN (per-pixel LUT bypass by bit replication).
module hub75_gamma_seq #(
  parameter int IW = 8,
  parameter int OW = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  hub75_gamma_seq_if.master     bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LK_G = 3'd1,
    LK_B = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            last_pix;   // 1: pixel side won the last grant
  logic [3*IW-1:0] pix_q;
  logic [OW-1:0]   r_q, g_q;
  logic            byp_now, byp_q;
  logic            grant_pix, grant_wr;

`ifdef HUB75_GAMMA_SEQ_BYPASS_EN
  assign byp_now = bus.bypass;

  // Replicate the input bits MSB-first until OW bits are filled.
  function automatic logic [OW-1:0] expand(input logic [IW-1:0] v);
    logic [OW-1:0] e;
    for (int i = 0; i < OW; i++) e[OW-1-i] = v[IW-1-(i%IW)];
    return e;
  endfunction
`else
  assign byp_now = 1'b0;
`endif

  assign state_dbg    = state;
  assign bus.in_ready = grant_pix;
  assign bus.wr_ready = grant_wr;

  always_comb begin
    state_nxt     = state;
    grant_pix     = 1'b0;
    grant_wr      = 1'b0;
    bus.lut_addr  = '0;
    bus.lut_rden  = 1'b0;
    bus.lut_wren  = 1'b0;
    bus.lut_wdata = '0;
    case (state)
      IDLE: begin
        // Grants are suppressed during reset so no half-issued host write reaches the LUT.
        if (!rst) begin
          if (bus.in_valid && (!bus.wr_valid || !last_pix)) begin
            grant_pix    = 1'b1;
            bus.lut_rden = !byp_now;
            bus.lut_addr = bus.in_data[3*IW-1 -: IW];
            state_nxt    = LK_G;
          end else if (bus.wr_valid) begin
            grant_wr      = 1'b1;
            bus.lut_wren  = 1'b1;
            bus.lut_addr  = bus.wr_addr;
            bus.lut_wdata = bus.wr_data;
          end
        end
      end
      LK_G: begin
        bus.lut_rden = !byp_q;
        bus.lut_addr = pix_q[2*IW-1 -: IW];
        state_nxt    = LK_B;
      end
      LK_B: begin
        bus.lut_rden = !byp_q;
        bus.lut_addr = pix_q[IW-1:0];
        state_nxt    = CAP;
      end
      CAP:     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_pix      <= 1'b0;
      pix_q         <= '0;
      r_q           <= '0;
      g_q           <= '0;
      byp_q         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_pix) begin
        pix_q    <= bus.in_data;
        byp_q    <= byp_now;
        last_pix <= 1'b1;
      end
      if (grant_wr) last_pix <= 1'b0;
      // Read data lags the strobe by one cycle, so each state captures the previous channel.
      if (state == LK_G) r_q <= bus.lut_rdata;
      if (state == LK_B) g_q <= bus.lut_rdata;
      if (state == CAP) begin
        bus.out_valid <= 1'b1;
`ifdef HUB75_GAMMA_SEQ_BYPASS_EN
        if (byp_q)
          bus.out_data <= {expand(pix_q[3*IW-1 -: IW]), expand(pix_q[2*IW-1 -: IW]),
                           expand(pix_q[IW-1:0])};
        else
          bus.out_data <= {r_q, g_q, bus.lut_rdata};
`else
        bus.out_data <= {r_q, g_q, bus.lut_rdata};
`endif
      end
      if (state == OUT && bus.out_ready) bus.out_valid <= 1'b0;
    end
  end

endmodule
